// File: rtl/ex_mdu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : ex_mdu_pkg                                                       |
// | Brief   : RV32M opcode/funct3 selectors, MDU state encoding and helpers.   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package ex_mdu_pkg;

    // R-type opcode; funct7 picks the M extension out of it
    localparam logic [6:0] INST_TYPE_R_M = 7'b0110011;
    localparam logic [6:0] INST_FUNCT7_M = 7'b0000001;

    localparam logic [2:0] INST_MUL    = 3'b000;
    localparam logic [2:0] INST_MULH   = 3'b001;
    localparam logic [2:0] INST_MULHSU = 3'b010;
    localparam logic [2:0] INST_MULHU  = 3'b011;
    localparam logic [2:0] INST_DIV    = 3'b100;
    localparam logic [2:0] INST_DIVU   = 3'b101;
    localparam logic [2:0] INST_REM    = 3'b110;
    localparam logic [2:0] INST_REMU   = 3'b111;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_CALC = 2'd1,
        MDU_FIX  = 2'd2,
        MDU_DONE = 2'd3
    } mdu_state_t;

    function automatic logic op1_is_signed(input logic [2:0] f3);
        return (f3 == INST_MULH) || (f3 == INST_MULHSU) ||
               (f3 == INST_DIV)  || (f3 == INST_REM);
    endfunction

    function automatic logic op2_is_signed(input logic [2:0] f3);
        return (f3 == INST_MULH) || (f3 == INST_DIV) || (f3 == INST_REM);
    endfunction

    function automatic logic is_div_op(input logic [2:0] f3);
        return f3[2];
    endfunction

endpackage
`default_nettype wire

// File: rtl/ex_mdu_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : ex_mdu_if                                                        |
// | Brief   : Issue/writeback bundle between id_ex, control and the MDU.       |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
interface ex_mdu_if #(
    parameter int XLEN = 32
);
    logic            start_i;
    logic [2:0]      funct3_i;
    logic [XLEN-1:0] op1_i;
    logic [XLEN-1:0] op2_i;
    logic [4:0]      rd_addr_i;
    logic            flush_i;
    logic            hold_flag_o;
    logic            done_o;
    logic [4:0]      rd_addr_o;
    logic [XLEN-1:0] rd_data_o;
    logic            rd_wen_o;

    modport master (
        output start_i, funct3_i, op1_i, op2_i, rd_addr_i, flush_i,
        input  hold_flag_o, done_o, rd_addr_o, rd_data_o, rd_wen_o
    );

    modport slave (
        input  start_i, funct3_i, op1_i, op2_i, rd_addr_i, flush_i,
        output hold_flag_o, done_o, rd_addr_o, rd_data_o, rd_wen_o
    );
endinterface
`default_nettype wire

// File: rtl/ex_mdu_step.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : mdu_step                                                         |
// | Brief   : One MDU iteration: STEP_BITS of shift-add or restoring divide.   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module mdu_step #(
    parameter int XLEN      = 32,
    parameter int STEP_BITS = 1
) (
    input  wire logic [2*XLEN:0]   acc_i,
    input  wire logic [XLEN-1:0]   operand_i,
    input  wire logic              div_mode_i,
    output logic      [2*XLEN:0]   acc_o
);
    localparam int SUM_W = XLEN + STEP_BITS + 1;

    logic [SUM_W-1:0]              w_hi;
    logic [SUM_W-1:0]              w_mcand;
    logic [SUM_W-1:0]              w_mbits;
    logic [SUM_W-1:0]              w_sum;
    logic [SUM_W+XLEN-1:0]         w_mul_cat;
    logic [2*XLEN:0]               w_div_acc;
    logic [XLEN+1:0]               w_diff;

    // Multiply: acc = {partial product, remaining multiplier bits}
    always_comb begin
        w_hi      = {{STEP_BITS{1'b0}}, acc_i[2*XLEN:XLEN]};
        w_mcand   = {{(STEP_BITS+1){1'b0}}, operand_i};
        w_mbits   = {{(XLEN+1){1'b0}}, acc_i[STEP_BITS-1:0]};
        w_sum     = w_hi + (w_mcand * w_mbits);
        w_mul_cat = {w_sum, acc_i[XLEN-1:0]};
    end

    // Divide: acc = {partial remainder (XLEN+1), dividend/quotient}
    always_comb begin
        w_div_acc = acc_i;
        w_diff    = '0;
        for (int i = 0; i < STEP_BITS; i++) begin
            w_div_acc = {w_div_acc[2*XLEN-1:0], 1'b0};
            w_diff    = {1'b0, w_div_acc[2*XLEN:XLEN]} - {2'b00, operand_i};
            if (!w_diff[XLEN+1]) begin
                w_div_acc[2*XLEN:XLEN] = w_diff[XLEN:0];
                w_div_acc[0]           = 1'b1;
            end
        end
    end

    assign acc_o = div_mode_i ? w_div_acc : w_mul_cat[2*XLEN+STEP_BITS:STEP_BITS];

endmodule
`default_nettype wire

// File: rtl/ex_mdu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : ex_mdu                                                           |
// | Brief   : Multi-cycle RV32M multiply/divide unit in the execute stage.     |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module ex_mdu
    import ex_mdu_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int STEP_BITS = 1
) (
    input  wire logic clk,
    input  wire logic rst_n,
    ex_mdu_if.slave   mdu_if
);
    localparam int ITER  = XLEN / STEP_BITS;
    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CNT_W-1:0] C_LAST    = CNT_W'(ITER - 1);
    localparam logic [XLEN-1:0]  C_MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_t        r_state;
    mdu_state_t        w_next_state;
    logic [2:0]        r_funct3;
    logic [4:0]        r_rd_addr;
    logic [2*XLEN:0]   r_acc;
    logic [XLEN-1:0]   r_operand;
    logic              r_neg_res;
    logic              r_neg_rem;
    logic [CNT_W-1:0]  r_cnt;
    logic [XLEN-1:0]   r_rd_data;

    logic              w_accept;
    logic              w_hold;
    logic              w_done;
    logic              w_op1_neg;
    logic              w_op2_neg;
    logic [XLEN-1:0]   w_mag1;
    logic [XLEN-1:0]   w_mag2;
    logic              w_div0;
    logic              w_ovf;
    logic              w_special;
    logic [XLEN-1:0]   w_special_data;
    logic [2*XLEN:0]   w_step_acc;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quot;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_fix_data;

    // Operand conditioning at accept: magnitudes plus sign flags
    always_comb begin
        w_op1_neg = op1_is_signed(mdu_if.funct3_i) && mdu_if.op1_i[XLEN-1];
        w_op2_neg = op2_is_signed(mdu_if.funct3_i) && mdu_if.op2_i[XLEN-1];
        w_mag1    = w_op1_neg ? -mdu_if.op1_i : mdu_if.op1_i;
        w_mag2    = w_op2_neg ? -mdu_if.op2_i : mdu_if.op2_i;
        w_div0    = is_div_op(mdu_if.funct3_i) && (mdu_if.op2_i == '0);
        w_ovf     = ((mdu_if.funct3_i == INST_DIV) || (mdu_if.funct3_i == INST_REM)) &&
                    (mdu_if.op1_i == C_MIN_INT) && (mdu_if.op2_i == '1);
        w_special = w_div0 || w_ovf;
        if (w_div0) begin
            w_special_data = mdu_if.funct3_i[1] ? mdu_if.op1_i : '1;
        end else begin
            w_special_data = mdu_if.funct3_i[1] ? '0 : C_MIN_INT;
        end
    end

    mdu_step #(
        .XLEN      (XLEN),
        .STEP_BITS (STEP_BITS)
    ) u_mdu_step (
        .acc_i      (r_acc),
        .operand_i  (r_operand),
        .div_mode_i (is_div_op(r_funct3)),
        .acc_o      (w_step_acc)
    );

    // Sign fix-up and result selection
    always_comb begin
        w_prod = r_neg_res ? -r_acc[2*XLEN-1:0] : r_acc[2*XLEN-1:0];
        w_quot = r_neg_res ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
        w_rem  = r_neg_rem ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
        if (is_div_op(r_funct3)) begin
            w_fix_data = r_funct3[1] ? w_rem : w_quot;
        end else begin
            w_fix_data = (r_funct3 == INST_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= MDU_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_hold       = 1'b0;
        w_done       = 1'b0;
        unique case (r_state)
            MDU_IDLE: begin
                w_accept = mdu_if.start_i && !mdu_if.flush_i;
                w_hold   = w_accept;
                if (w_accept) begin
                    w_next_state = w_special ? MDU_DONE : MDU_CALC;
                end
            end
            MDU_CALC: begin
                w_hold = !mdu_if.flush_i;
                if (mdu_if.flush_i) begin
                    w_next_state = MDU_IDLE;
                end else if (r_cnt == C_LAST) begin
                    w_next_state = MDU_FIX;
                end
            end
            MDU_FIX: begin
                w_hold       = !mdu_if.flush_i;
                w_next_state = mdu_if.flush_i ? MDU_IDLE : MDU_DONE;
            end
            MDU_DONE: begin
                w_done       = !mdu_if.flush_i;
                w_next_state = MDU_IDLE;
            end
            default: w_next_state = MDU_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_funct3  <= '0;
            r_rd_addr <= '0;
            r_acc     <= '0;
            r_operand <= '0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_cnt     <= '0;
            r_rd_data <= '0;
        end else begin
            case (r_state)
                MDU_IDLE: begin
                    if (w_accept) begin
                        r_funct3  <= mdu_if.funct3_i;
                        r_rd_addr <= mdu_if.rd_addr_i;
                        r_cnt     <= '0;
                        r_neg_res <= w_op1_neg ^ w_op2_neg;
                        r_neg_rem <= w_op1_neg;
                        // Divide iterates the dividend, multiply the multiplier
                        if (is_div_op(mdu_if.funct3_i)) begin
                            r_acc     <= {{(XLEN+1){1'b0}}, w_mag1};
                            r_operand <= w_mag2;
                        end else begin
                            r_acc     <= {{(XLEN+1){1'b0}}, w_mag2};
                            r_operand <= w_mag1;
                        end
                        if (w_special) begin
                            r_rd_data <= w_special_data;
                        end
                    end
                end
                MDU_CALC: begin
                    r_acc <= w_step_acc;
                    r_cnt <= r_cnt + 1'b1;
                end
                MDU_FIX: begin
                    if (!mdu_if.flush_i) begin
                        r_rd_data <= w_fix_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mdu_if.hold_flag_o = w_hold;
    assign mdu_if.done_o      = w_done;
    assign mdu_if.rd_wen_o    = w_done && (r_rd_addr != 5'd0);
    assign mdu_if.rd_addr_o   = r_rd_addr;
    assign mdu_if.rd_data_o   = r_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_ex_mdu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_ex_mdu                                                        |
// | Brief   : Directed vectors for ex_mdu at STEP_BITS=1 and STEP_BITS=4.      |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_ex_mdu;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  rd_addr;
    logic        flush;

    int n_vec;
    int n_bad;

    ex_mdu_if #(.XLEN(32)) b1 ();
    ex_mdu_if #(.XLEN(32)) b4 ();

    assign b1.start_i   = start;
    assign b1.funct3_i  = funct3;
    assign b1.op1_i     = op1;
    assign b1.op2_i     = op2;
    assign b1.rd_addr_i = rd_addr;
    assign b1.flush_i   = flush;
    assign b4.start_i   = start;
    assign b4.funct3_i  = funct3;
    assign b4.op1_i     = op1;
    assign b4.op2_i     = op2;
    assign b4.rd_addr_i = rd_addr;
    assign b4.flush_i   = flush;

    ex_mdu #(.XLEN(32), .STEP_BITS(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .mdu_if(b1.slave));
    ex_mdu #(.XLEN(32), .STEP_BITS(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .mdu_if(b4.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        int          lat1;
        int          lat4;
        int          poke;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [39:0] outs1();
        return {3'b000, b1.hold_flag_o, b1.done_o, b1.rd_wen_o, b1.rd_addr_o, b1.rd_data_o};
    endfunction

    function automatic logic [39:0] outs4();
        return {3'b000, b4.hold_flag_o, b4.done_o, b4.rd_wen_o, b4.rd_addr_o, b4.rd_data_o};
    endfunction

    // Called at #1 after a rising edge with both units idle; that cycle is T
    task automatic run_op(input vec_t v);
        int          k1, k4, n1, n4;
        logic [31:0] d1, d4;
        logic [5:0]  aw1, aw4;
        bit          hold_ok;
        k1 = -1; k4 = -1; n1 = 0; n4 = 0;
        d1 = '0; d4 = '0; aw1 = '0; aw4 = '0;
        start = 1'b1; funct3 = v.f3; op1 = v.a; op2 = v.b; rd_addr = v.rd;
        @(negedge clk);
        hold_ok = (b1.hold_flag_o === 1'b1) && (b4.hold_flag_o === 1'b1) &&
                  (b1.done_o === 1'b0) && (b4.done_o === 1'b0);
        next_cycle();
        start = 1'b0; funct3 = '0; op1 = '0; op2 = '0; rd_addr = '0;
        for (int k = 1; k <= 40; k++) begin
            if (k == v.poke) begin
                start = 1'b1; funct3 = 3'b000; op1 = 32'd3; op2 = 32'd4; rd_addr = 5'd1;
            end
            @(negedge clk);
            if (b1.done_o === 1'b1) begin
                n1++; k1 = k; d1 = b1.rd_data_o; aw1 = {b1.rd_addr_o, b1.rd_wen_o};
            end
            if (b4.done_o === 1'b1) begin
                n4++; k4 = k; d4 = b4.rd_data_o; aw4 = {b4.rd_addr_o, b4.rd_wen_o};
            end
            if (b1.hold_flag_o !== (k < v.lat1)) hold_ok = 1'b0;
            if (b4.hold_flag_o !== (k < v.lat4)) hold_ok = 1'b0;
            next_cycle();
            start = 1'b0; funct3 = '0; op1 = '0; op2 = '0; rd_addr = '0;
        end
        check({v.name, " s1 latency"}, 64'(k1), 64'(v.lat1));
        check({v.name, " s1 done count"}, 64'(n1), 64'd1);
        check({v.name, " s1 rd_data"}, 64'(d1), 64'(v.exp));
        check({v.name, " s1 rd_addr/wen"}, 64'(aw1), 64'({v.rd, v.rd != 5'd0}));
        check({v.name, " s4 latency"}, 64'(k4), 64'(v.lat4));
        check({v.name, " s4 done count"}, 64'(n4), 64'd1);
        check({v.name, " s4 rd_data"}, 64'(d4), 64'(v.exp));
        check({v.name, " s4 rd_addr/wen"}, 64'(aw4), 64'({v.rd, v.rd != 5'd0}));
        check({v.name, " hold profile"}, 64'(hold_ok), 64'd1);
    endtask

    initial begin
        vec_t fv;
        int   nd1, nd4;
        n_vec = 0; n_bad = 0;
        rst_n = 1'b0; start = 1'b0; funct3 = '0; op1 = '0; op2 = '0; rd_addr = '0; flush = 1'b0;

        //                name       f3      a             b             rd     exp          l1  l4 poke
        vecs.push_back('{"MUL",    3'b000, 32'h00000007, 32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 34, 10, 0});
        vecs.push_back('{"MULH",   3'b001, 32'h80000000, 32'h80000000, 5'd6,  32'h40000000, 34, 10, 0});
        vecs.push_back('{"MULHU",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'hFFFFFFFE, 34, 10, 0});
        vecs.push_back('{"MULHSU", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8,  32'hFFFFFFFF, 34, 10, 0});
        vecs.push_back('{"MUL2",   3'b000, 32'h0000FFFF, 32'h0000FFFF, 5'd9,  32'hFFFE0001, 34, 10, 0});
        vecs.push_back('{"MULH2",  3'b001, 32'hFFFFFFFF, 32'h00000002, 5'd10, 32'hFFFFFFFF, 34, 10, 0});
        vecs.push_back('{"MULHU2", 3'b011, 32'h80000000, 32'h00000004, 5'd23, 32'h00000002, 34, 10, 0});
        vecs.push_back('{"MUL_X0", 3'b000, 32'h00000003, 32'h00000004, 5'd0,  32'h0000000C, 34, 10, 0});
        vecs.push_back('{"DIV",    3'b100, 32'hFFFFFFF9, 32'h00000002, 5'd11, 32'hFFFFFFFD, 34, 10, 0});
        vecs.push_back('{"REM",    3'b110, 32'hFFFFFFF9, 32'h00000002, 5'd12, 32'hFFFFFFFF, 34, 10, 0});
        vecs.push_back('{"DIV2",   3'b100, 32'h00000064, 32'hFFFFFFF9, 5'd13, 32'hFFFFFFF2, 34, 10, 0});
        vecs.push_back('{"REM2",   3'b110, 32'hFFFFFF9C, 32'h00000007, 5'd14, 32'hFFFFFFFE, 34, 10, 0});
        vecs.push_back('{"DIVU",   3'b101, 32'h00000064, 32'h00000007, 5'd15, 32'h0000000E, 34, 10, 2});
        vecs.push_back('{"REMU",   3'b111, 32'h00000064, 32'h00000007, 5'd16, 32'h00000002, 34, 10, 0});
        vecs.push_back('{"DIVU_0", 3'b101, 32'h00001234, 32'h00000000, 5'd17, 32'hFFFFFFFF, 1,  1,  0});
        vecs.push_back('{"REMU_0", 3'b111, 32'h00001234, 32'h00000000, 5'd18, 32'h00001234, 1,  1,  0});
        vecs.push_back('{"DIV_OV", 3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd19, 32'h80000000, 1,  1,  0});
        vecs.push_back('{"REM_OV", 3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd20, 32'h00000000, 1,  1,  0});
        vecs.push_back('{"REM_0",  3'b110, 32'hFFFFFFFB, 32'h00000000, 5'd21, 32'hFFFFFFFB, 1,  1,  0});
        vecs.push_back('{"DIV_0",  3'b100, 32'h00000005, 32'h00000000, 5'd22, 32'hFFFFFFFF, 1,  1,  0});

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset outs s1", 64'(outs1()), 64'd0);
        check("reset outs s4", 64'(outs4()), 64'd0);
        next_cycle();
        rst_n = 1'b1;
        next_cycle();

        foreach (vecs[i]) run_op(vecs[i]);

        // Flush during CALC at T+5, then a fresh MUL at T+6
        nd1 = 0; nd4 = 0;
        start = 1'b1; funct3 = 3'b100; op1 = 32'd100; op2 = 32'd7; rd_addr = 5'd4;
        next_cycle();
        start = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            nd1 += int'(b1.done_o); nd4 += int'(b4.done_o);
            next_cycle();
        end
        flush = 1'b1;
        @(negedge clk);
        check("flush calc hold s1", 64'(b1.hold_flag_o), 64'd0);
        check("flush calc hold s4", 64'(b4.hold_flag_o), 64'd0);
        nd1 += int'(b1.done_o); nd4 += int'(b4.done_o);
        check("flush calc no done", 64'(nd1 + nd4), 64'd0);
        next_cycle();
        flush = 1'b0;
        fv = '{"MUL_AFTER_FLUSH", 3'b000, 32'd3, 32'd4, 5'd3, 32'd12, 34, 10, 0};
        run_op(fv);

        // Flush in DONE of a special-case op suppresses the writeback
        nd1 = 0; nd4 = 0;
        start = 1'b1; funct3 = 3'b101; op1 = 32'h1234; op2 = 32'd0; rd_addr = 5'd2;
        next_cycle();
        start = 1'b0; flush = 1'b1;
        @(negedge clk);
        check("flush done s1", 64'({b1.done_o, b1.rd_wen_o, b1.hold_flag_o}), 64'd0);
        check("flush done s4", 64'({b4.done_o, b4.rd_wen_o, b4.hold_flag_o}), 64'd0);
        next_cycle();
        flush = 1'b0;
        for (int k = 2; k <= 5; k++) begin
            @(negedge clk);
            nd1 += int'(b1.done_o); nd4 += int'(b4.done_o);
            next_cycle();
        end
        check("flush done later", 64'(nd1 + nd4), 64'd0);

        // Reset at T+10 of a DIV discards it
        nd1 = 0; nd4 = 0;
        start = 1'b1; funct3 = 3'b100; op1 = 32'hFFFFFFF9; op2 = 32'd2; rd_addr = 5'd7;
        next_cycle();
        start = 1'b0;
        repeat (9) next_cycle();
        rst_n = 1'b0;
        #1;
        check("midop reset s1", 64'(outs1()), 64'd0);
        check("midop reset s4", 64'(outs4()), 64'd0);
        repeat (2) next_cycle();
        rst_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            nd1 += int'(b1.done_o); nd4 += int'(b4.done_o);
            next_cycle();
        end
        check("no done after reset s1", 64'(nd1), 64'd0);
        check("no done after reset s4", 64'(nd4), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ex_mdu.md
Name: ex_mdu

Overview:
Multi-cycle multiply/divide unit for the RV32M extension, in the execute stage beside the single-cycle ALU.
- Accepts one MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU op from id_ex.
- Iterates a configurable number of result bits per cycle.
- Raises hold_flag_o toward control while busy.
- Returns the rd writeback to ex_mem with a one-cycle done pulse.

Parameters:
XLEN, 32, operand/result width; must be a multiple of STEP_BITS.
STEP_BITS, 1, quotient/multiplier bits retired per iteration cycle (1, 2 or 4).
ITER, XLEN/STEP_BITS, derived localparam: iteration cycles per operation.

Ports:
clk  in  1  core clock
rst_n  in  1  reset; asynchronous, active-low
start_i  in  1  valid M-extension op presented this cycle
funct3_i  in  3  M-op select, RV32M funct3 encoding (000 MUL … 111 REMU)
op1_i  in  XLEN  rs1 value (forwarded)
op2_i  in  XLEN  rs2 value (forwarded)
rd_addr_i  in  5  destination register
flush_i  in  1  control-issued kill (jump/branch taken ahead)
hold_flag_o  out  1  stall request to control
done_o  out  1  one-cycle result-valid pulse
rd_addr_o  out  5  destination register of completed op
rd_data_o  out  XLEN  result
rd_wen_o  out  1  write enable; equals done_o AND rd_addr_o!=0

Behaviour:
Reset:
- All outputs are 0 and the state is IDLE.
- Reset mid-operation discards the op; no done_o follows.

States: IDLE, CALC, FIX, DONE.
- IDLE: start_i=1 and flush_i=0 means accept.
  - Latch funct3, rd_addr, operand magnitudes and result-sign flags.
  - Signedness: DIV/REM/MULH use both operands signed; MULHSU uses op1 signed, op2 unsigned; others unsigned.
  - Clear the iteration counter and go to CALC.
  - Special cases go to DONE directly, result registered at accept:
    - op2=0 with DIV/DIVU: result all-ones. With REM/REMU: result = op1.
    - DIV with op1=MIN_INT and op2=-1: result MIN_INT. REM with the same operands: result 0.
- CALC: run ITER cycles.
  - Multiply: shift-add, STEP_BITS of the multiplier per cycle into a 2*XLEN accumulator.
  - Divide: restoring, STEP_BITS quotient bits per cycle.
  - Go to FIX when the counter reaches ITER-1.
- FIX: one cycle.
  - Negate the product if the sign flags differ.
  - Negate the quotient if the operand signs differ.
  - Give the remainder the dividend's sign.
  - Select the result: MUL takes the low XLEN bits, MULH* the high XLEN bits.
  - Register rd_data_o; go to DONE.
- DONE: done_o=1 and rd_wen_o as defined, for exactly one cycle; return to IDLE.
  - rd_data_o/rd_addr_o hold until the next accept.
  - start_i in DONE is ignored; control re-presents it after the stall releases.

Latency and stall:
- Accept at cycle T gives done at T+ITER+2; special cases give done at T+1.
- hold_flag_o = start_i&&state==IDLE&&!flush_i, OR state in {CALC, FIX}. It is combinational, so the accepting cycle already stalls. It is low in DONE so the pipeline advances with the result.

Boundary conditions:
- start_i while in CALC/FIX is ignored and has no side effects.
- flush_i in CALC/FIX returns the unit to IDLE next cycle. No done_o. hold_flag_o drops the same cycle.
- flush_i in DONE suppresses done_o/rd_wen_o.
- flush_i with start_i in IDLE: no accept.
- All arithmetic wraps modulo 2^XLEN. The accumulator is 2*XLEN+1 bits to hold the divide borrow.

Decomposition:
- Shared defines: the RV32M funct3 constants (INST_MUL..INST_REMU), INST_TYPE_R_M opcode and funct7 0000001 selector, added next to the existing R-type constants.
- One sub-module: mdu_step. Combinational, parametrised by XLEN and STEP_BITS. Performs one iteration on {accumulator, operand, mode}; instantiated once inside ex_mdu.

Test Plan:
- MUL 7 × 0xFFFFFFFD (−3) -> rd_data 0xFFFFFFEB; done_o at T+34 (STEP_BITS=1); hold_flag_o high T..T+33.
- MULH 0x80000000×0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (−7) / 2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. Repeat with STEP_BITS=4: done at T+10, same results.
- DIVU 0x1234 / 0 -> 0xFFFFFFFF; REMU 0x1234 / 0 -> 0x1234. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0. All with done at T+1.
- Start DIV, assert flush_i at T+5 -> hold_flag_o low at T+5, no done_o. A new MUL 3×4 at T+6 -> 12.
- Start MUL with rd_addr=0 -> done_o pulses, rd_wen_o stays 0. rst_n low at T+10 of a DIV -> all outputs 0 immediately; no done after release.
